// File: rtl/rr_arbiter8.sv
`default_nettype none
// ============================================================================
// Module   : rr_arbiter8
// Brief    : 8-way round-robin arbiter with registered select/enable and hold timeout
// Revision : 1.0 - initial release
// ============================================================================
module rr_arbiter8 #(
  parameter int N        = 8,
  parameter int IDX_W    = 3,
  parameter int MAX_HOLD = 15
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N-1:0]     req,
  input  logic             done,
  output logic [N-1:0]     grant,
  output logic [IDX_W-1:0] grant_idx,
  output logic             grant_en,
  output logic             timeout
);

  localparam int CNT_W = $clog2(MAX_HOLD + 1);

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_OWN  = 1'b1
  } state_t;

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   ptr_q, ptr_d;
  logic [IDX_W-1:0]   grant_idx_q, grant_idx_d;
  logic               grant_en_q, grant_en_d;
  logic [CNT_W-1:0]   hold_q, hold_d;
  logic               timeout_q, timeout_d;

  logic [IDX_W-1:0]   winner;
  logic               found;
  logic [IDX_W-1:0]   cand;
  logic               rel_done, rel_drop, rel_max;

  // First set request at or above ptr; IDX_W-bit addition gives the wrap for free.
  always_comb begin
    winner = ptr_q;
    found  = 1'b0;
    cand   = ptr_q;
    for (int i = 0; i < N; i++) begin
      cand = ptr_q + IDX_W'(i);
      if (!found && req[cand]) begin
        winner = cand;
        found  = 1'b1;
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    grant_idx_d = grant_idx_q;
    grant_en_d  = grant_en_q;
    hold_d      = hold_q;
    timeout_d   = 1'b0;
    rel_done    = done;
    rel_drop    = !req[grant_idx_q];
    rel_max     = (hold_q == CNT_W'(MAX_HOLD));

    case (state_q)
      S_IDLE: begin
        if (found) begin
          grant_idx_d = winner;
          grant_en_d  = 1'b1;
          hold_d      = CNT_W'(1);
          state_d     = S_OWN;
        end
      end
      S_OWN: begin
        if (rel_done || rel_drop || rel_max) begin
          grant_en_d = 1'b0;
          hold_d     = '0;
          ptr_d      = grant_idx_q + IDX_W'(1);
          timeout_d  = rel_max && !rel_done && !rel_drop;
          state_d    = S_IDLE;
        end else begin
          hold_d = hold_q + CNT_W'(1);
        end
      end
      default: begin
        state_d    = S_IDLE;
        grant_en_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      ptr_q       <= '0;
      grant_idx_q <= '0;
      grant_en_q  <= 1'b0;
      hold_q      <= '0;
      timeout_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      grant_idx_q <= grant_idx_d;
      grant_en_q  <= grant_en_d;
      hold_q      <= hold_d;
      timeout_q   <= timeout_d;
    end
  end

  generate
    for (genvar k = 0; k < N; k++) begin : g_grant
      assign grant[k] = grant_en_q && (grant_idx_q == IDX_W'(k));
    end
  endgenerate

  assign grant_idx = grant_idx_q;
  assign grant_en  = grant_en_q;
  assign timeout   = timeout_q;

endmodule
`default_nettype wire

// File: tb/tb_rr_arbiter8.sv
`default_nettype none
// ============================================================================
// Module   : tb_rr_arbiter8
// Brief    : Self-checking bench for rr_arbiter8 (vector table, corner sequences, random vs model)
// Revision : 1.0 - initial release
// ============================================================================
module tb_rr_arbiter8;

  localparam int N        = 8;
  localparam int IDX_W    = 3;
  localparam int MAX_HOLD = 15;

  logic             clk;
  logic             rst;
  logic [N-1:0]     req;
  logic             done;
  logic [N-1:0]     grant;
  logic [IDX_W-1:0] grant_idx;
  logic             grant_en;
  logic             timeout;

  int n_vec = 0;
  int n_err = 0;

  // Reference state: who owns the resource, where the search starts, how long held.
  int m_owner;
  int m_last;
  int m_ptr;
  int m_hold;
  bit m_to;

  rr_arbiter8 #(.N(N), .IDX_W(IDX_W), .MAX_HOLD(MAX_HOLD)) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .done      (done),
    .grant     (grant),
    .grant_idx (grant_idx),
    .grant_en  (grant_en),
    .timeout   (timeout)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic       rst;
    logic [7:0] req;
    logic       done;
    logic       en;
    logic [2:0] idx;
    logic [7:0] gnt;
    logic       to;
  } vec_t;

  vec_t tbl[22];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_edge(input logic r, input logic [7:0] rq, input logic d);
    bit by_done, by_drop, by_max, hit;
    int slot;
    if (r) begin
      m_owner = -1; m_last = 0; m_ptr = 0; m_hold = 0; m_to = 0;
    end else if (m_owner < 0) begin
      m_to = 0;
      hit  = 0;
      for (int k = 0; k < N; k++) begin
        slot = (m_ptr + k) % N;
        if (!hit && rq[slot]) begin
          hit = 1; m_owner = slot; m_last = slot; m_hold = 1;
        end
      end
    end else begin
      by_done = d;
      by_drop = !rq[m_owner];
      by_max  = (m_hold == MAX_HOLD);
      if (by_done || by_drop || by_max) begin
        m_to    = by_max && !by_done && !by_drop;
        m_ptr   = (m_owner + 1) % N;
        m_owner = -1;
      end else begin
        m_hold++;
        m_to = 0;
      end
    end
  endtask

  task automatic step(input logic r, input logic [7:0] rq, input logic d);
    rst = r; req = rq; done = d;
    @(posedge clk);
    model_edge(r, rq, d);
    #1;
  endtask

  task automatic check_model(input string tag);
    logic [7:0] exp_g;
    exp_g = (m_owner >= 0) ? (8'h01 << m_owner) : 8'h00;
    check({tag, ".grant_en"},  {31'd0, grant_en}, {31'd0, (m_owner >= 0)});
    check({tag, ".grant_idx"}, {29'd0, grant_idx}, m_last);
    check({tag, ".grant"},     {24'd0, grant}, {24'd0, exp_g});
    check({tag, ".timeout"},   {31'd0, timeout}, {31'd0, m_to});
    check({tag, ".onehot"},    {31'd0, ($onehot0(grant) && (grant_en == |grant))}, 32'd1);
  endtask

  initial begin
    int cnt, guard;
    logic [7:0] rq;

    rst = 1'b1; req = '0; done = 1'b0;
    m_owner = -1; m_last = 0; m_ptr = 0; m_hold = 0; m_to = 0;

    // rst, req, done | en, idx, grant, timeout
    tbl[0]  = '{1'b1, 8'h00, 1'b0, 1'b0, 3'd0, 8'h00, 1'b0};
    tbl[1]  = '{1'b1, 8'hFF, 1'b1, 1'b0, 3'd0, 8'h00, 1'b0};
    tbl[2]  = '{1'b0, 8'h00, 1'b0, 1'b0, 3'd0, 8'h00, 1'b0};
    tbl[3]  = '{1'b0, 8'h00, 1'b0, 1'b0, 3'd0, 8'h00, 1'b0};
    tbl[4]  = '{1'b0, 8'h00, 1'b0, 1'b0, 3'd0, 8'h00, 1'b0};
    tbl[5]  = '{1'b0, 8'h00, 1'b0, 1'b0, 3'd0, 8'h00, 1'b0};
    tbl[6]  = '{1'b0, 8'h00, 1'b0, 1'b0, 3'd0, 8'h00, 1'b0};
    tbl[7]  = '{1'b0, 8'h10, 1'b0, 1'b1, 3'd4, 8'h10, 1'b0};
    tbl[8]  = '{1'b0, 8'h10, 1'b0, 1'b1, 3'd4, 8'h10, 1'b0};
    tbl[9]  = '{1'b0, 8'h10, 1'b1, 1'b0, 3'd4, 8'h00, 1'b0};
    tbl[10] = '{1'b0, 8'h00, 1'b0, 1'b0, 3'd4, 8'h00, 1'b0};
    tbl[11] = '{1'b0, 8'h21, 1'b0, 1'b1, 3'd5, 8'h20, 1'b0};
    tbl[12] = '{1'b0, 8'h01, 1'b0, 1'b0, 3'd5, 8'h00, 1'b0};
    tbl[13] = '{1'b0, 8'h01, 1'b0, 1'b1, 3'd0, 8'h01, 1'b0};
    tbl[14] = '{1'b0, 8'h01, 1'b1, 1'b0, 3'd0, 8'h00, 1'b0};
    tbl[15] = '{1'b0, 8'h00, 1'b0, 1'b0, 3'd0, 8'h00, 1'b0};
    tbl[16] = '{1'b0, 8'h40, 1'b0, 1'b1, 3'd6, 8'h40, 1'b0};
    tbl[17] = '{1'b0, 8'h40, 1'b1, 1'b0, 3'd6, 8'h00, 1'b0};
    tbl[18] = '{1'b0, 8'h01, 1'b0, 1'b1, 3'd0, 8'h01, 1'b0};
    tbl[19] = '{1'b0, 8'h00, 1'b0, 1'b0, 3'd0, 8'h00, 1'b0};
    tbl[20] = '{1'b0, 8'h00, 1'b0, 1'b0, 3'd0, 8'h00, 1'b0};
    tbl[21] = '{1'b0, 8'h00, 1'b1, 1'b0, 3'd0, 8'h00, 1'b0};

    for (int i = 0; i < 22; i++) begin
      step(tbl[i].rst, tbl[i].req, tbl[i].done);
      check($sformatf("tbl%0d.grant_en", i),  {31'd0, grant_en},  {31'd0, tbl[i].en});
      check($sformatf("tbl%0d.grant_idx", i), {29'd0, grant_idx}, {29'd0, tbl[i].idx});
      check($sformatf("tbl%0d.grant", i),     {24'd0, grant},     {24'd0, tbl[i].gnt});
      check($sformatf("tbl%0d.timeout", i),   {31'd0, timeout},   {31'd0, tbl[i].to});
    end

    // Rotation with all requesters active: 0..7 then back to 0, idle gap each time.
    step(1'b1, 8'h00, 1'b0);
    for (int k = 0; k < 9; k++) begin
      step(1'b0, 8'hFF, 1'b0);
      check($sformatf("rot%0d.idx", k), {29'd0, grant_idx}, k % N);
      check($sformatf("rot%0d.en", k),  {31'd0, grant_en}, 32'd1);
      step(1'b0, 8'hFF, 1'b1);
      check($sformatf("rot%0d.gap", k), {31'd0, grant_en}, 32'd0);
    end

    // Hold timeout: sole requester held with no done.
    step(1'b1, 8'h00, 1'b0);
    step(1'b0, 8'h04, 1'b0);
    cnt = grant_en ? 1 : 0;
    guard = 0;
    while (grant_en && guard < 40) begin
      check("to.early_pulse", {31'd0, timeout}, 32'd0);
      step(1'b0, 8'h04, 1'b0);
      if (grant_en) cnt++;
      guard++;
    end
    check("to.hold_cycles", cnt, MAX_HOLD);
    check("to.pulse", {31'd0, timeout}, 32'd1);
    check("to.gap_en", {31'd0, grant_en}, 32'd0);
    step(1'b0, 8'h04, 1'b0);
    check("to.regrant_en", {31'd0, grant_en}, 32'd1);
    check("to.regrant_idx", {29'd0, grant_idx}, 32'd2);
    check("to.pulse_one_cycle", {31'd0, timeout}, 32'd0);

    // done together with request drop: one release, no timeout.
    step(1'b1, 8'h00, 1'b0);
    step(1'b0, 8'h08, 1'b0);
    check("dd.idx", {29'd0, grant_idx}, 32'd3);
    step(1'b0, 8'h00, 1'b1);
    check("dd.en", {31'd0, grant_en}, 32'd0);
    check("dd.to", {31'd0, timeout}, 32'd0);

    // Reset mid-grant: outputs clear, no pulse, pointer back to 0.
    step(1'b0, 8'h80, 1'b0);
    check("rm.idx", {29'd0, grant_idx}, 32'd7);
    step(1'b1, 8'h80, 1'b0);
    check("rm.en", {31'd0, grant_en}, 32'd0);
    check("rm.grant", {24'd0, grant}, 32'd0);
    check("rm.idx0", {29'd0, grant_idx}, 32'd0);
    check("rm.to", {31'd0, timeout}, 32'd0);
    step(1'b0, 8'hFF, 1'b0);
    check("rm.ptr0", {29'd0, grant_idx}, 32'd0);

    // Randomized traffic against the reference model.
    step(1'b1, 8'h00, 1'b0);
    check_model("rnd_init");
    rq = 8'h00;
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 9) == 0) begin
        case ($urandom_range(0, 3))
          0: rq = 8'hFF;
          1: rq = 8'h01 << $urandom_range(0, 7);
          2: rq = 8'h00;
          default: rq = 8'($urandom);
        endcase
      end
      step(($urandom_range(0, 199) == 0), rq, ($urandom_range(0, 11) == 0));
      check_model($sformatf("rnd%0d", c));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
